// File: rtl/button_pkg.sv
// Shared button indices, count and debounce state encoding for the button conditioner.
package button_pkg;

  localparam int unsigned NUM_BTN    = 5;
  localparam int unsigned BTN_UP     = 0;
  localparam int unsigned BTN_DOWN   = 1;
  localparam int unsigned BTN_LEFT   = 2;
  localparam int unsigned BTN_RIGHT  = 3;
  localparam int unsigned BTN_CENTER = 4;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } db_state_e;

endpackage

// File: rtl/button_debounce_one.sv
// Single-button path: 2-flop synchronizer, debounce FSM with counter, registered level and edge pulses.
module button_debounce_one
  import button_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int unsigned CNT_W     = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (sync2_q) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!sync2_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_PRESSED;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PRESSED: begin
        if (!sync2_q) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (sync2_q) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pulses come from comparing the current state with the previous registered level,
  // so they land in the same cycle the registered level changes.
  always_comb begin
    level_d   = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_WAIT);
    press_d   = (state_q == ST_PRESSED) && !level_q;
    release_d = (state_q == ST_IDLE) && level_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/button_conditioner.sv
// Five independent debounced push-buttons with level, press/release pulses and an any-pressed flag.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int unsigned CNT_W     = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               any_level
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_debounce_one #(
      .DB_CYCLES(DB_CYCLES),
      .CNT_W    (CNT_W)
    ) u_db (
      .clk      (clk),
      .rst      (rst),
      .raw      (btn_raw[i]),
      .level_o  (btn_level[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i])
    );
  end

  assign any_level = |btn_level;

endmodule

// File: tb/tb_button_conditioner.sv
// Checks the button conditioner against a run-length acceptance model, with directed and random stimulus.
module tb_button_conditioner;
  import button_pkg::*;

  localparam int DB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] btn_raw = '0;
  logic [4:0] btn_level, btn_press, btn_release;
  logic       any_level;

  int total = 0;
  int bad   = 0;

  // Reference: a button's accepted level flips once its sampled input (two edges stale)
  // has disagreed with it on DB+1 consecutive edges; outputs show the accepted level one edge later.
  logic [4:0] m_d1 = '0, m_d2 = '0, m_acc = '0;
  logic [4:0] e_level = '0, e_press = '0, e_release = '0;
  int         run [5];

  button_conditioner #(.DB_CYCLES(DB), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .any_level  (any_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_level"}, btn_level, e_level);
    chk({tag, "_press"}, btn_press, e_press);
    chk({tag, "_release"}, btn_release, e_release);
    chk({tag, "_any"}, {4'b0, any_level}, {4'b0, |e_level});
    chk({tag, "_excl"}, btn_press & btn_release, 5'b0);
  endtask

  task automatic model_step();
    if (!rst) begin
      m_d1 = '0; m_d2 = '0; m_acc = '0;
      e_level = '0; e_press = '0; e_release = '0;
      for (int i = 0; i < 5; i++) run[i] = 0;
    end else begin
      e_press   = m_acc & ~e_level;
      e_release = ~m_acc & e_level;
      e_level   = m_acc;
      for (int i = 0; i < 5; i++) begin
        if (m_d2[i] !== m_acc[i]) begin
          run[i]++;
          if (run[i] == DB + 1) begin
            m_acc[i] = ~m_acc[i];
            run[i]   = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
      m_d2 = m_d1;
      m_d1 = btn_raw;
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    chk_outputs(tag);
  endtask

  initial begin
    int         lat;
    int         npress;
    logic [4:0] seen;
    logic [4:0] vec;
    int         len;

    for (int i = 0; i < 5; i++) run[i] = 0;

    // reset held, then released with buttons idle
    #1;
    chk_outputs("rst_async");
    repeat (5) cycle("rst_hold");
    rst = 1'b1;
    repeat (20) cycle("idle");

    // single press/release latency on right button
    btn_raw[BTN_RIGHT] = 1'b1;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      cycle("right_press");
      if (btn_press[BTN_RIGHT] && lat < 0) lat = k - 1;
    end
    chk_int("right_press_lat", lat, DB + 3);
    chk("right_level_held", {4'b0, btn_level[BTN_RIGHT]}, 5'b1);
    btn_raw[BTN_RIGHT] = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      cycle("right_release");
      if (btn_release[BTN_RIGHT] && lat < 0) lat = k - 1;
    end
    chk_int("right_release_lat", lat, DB + 3);
    chk("right_level_low", {4'b0, btn_level[BTN_RIGHT]}, 5'b0);

    // bounce shorter than the debounce window on up button
    seen = '0;
    for (int k = 0; k < 60; k++) begin
      btn_raw[BTN_UP] = ((k / 3) % 2) == 0;
      cycle("bounce");
      seen = seen | {2'b0, btn_level[BTN_UP], btn_press[BTN_UP], btn_release[BTN_UP]};
    end
    chk("bounce_quiet", seen, 5'b0);
    btn_raw = '0;
    repeat (20) cycle("bounce_settle");

    // simultaneous down+left
    btn_raw[BTN_DOWN] = 1'b1;
    btn_raw[BTN_LEFT] = 1'b1;
    seen = '0;
    for (int k = 1; k <= 40; k++) begin
      cycle("simul");
      if (btn_press != 5'b0 && seen == 5'b0) begin
        seen = btn_press;
        chk("simul_any", {4'b0, any_level}, 5'b1);
      end
    end
    chk("simul_press", seen, 5'b00110);
    btn_raw = '0;
    repeat (20) cycle("simul_settle");

    // reset during a held center press re-qualifies from idle
    btn_raw[BTN_CENTER] = 1'b1;
    repeat (5) cycle("center_pre");
    rst = 1'b0;
    #1;
    chk("center_rst_level", btn_level, 5'b0);
    chk("center_rst_press", btn_press, 5'b0);
    repeat (3) cycle("center_rst");
    rst = 1'b1;
    npress = 0;
    for (int k = 1; k <= 30; k++) begin
      cycle("center_after");
      if (btn_press[BTN_CENTER]) npress++;
    end
    chk_int("center_press_count", npress, 1);
    btn_raw = '0;
    repeat (20) cycle("center_settle");

    // random hold lengths straddling the debounce window
    for (int s = 0; s < 60; s++) begin
      vec = 5'($urandom);
      len = $urandom_range(14, 1);
      btn_raw = vec;
      repeat (len) cycle("rand");
    end
    btn_raw = '0;
    repeat (20) cycle("rand_settle");
    chk("final_level", btn_level, 5'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DB_CYCLES, default 1000000, is the number of consecutive stable clock cycles needed to accept a new button level (10 ms at 100 MHz); legal range 2..2^CNT_W-1.
REQ-002 Parameter CNT_W, default 20, is the width of each debounce counter.
REQ-003 Port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-low.
REQ-005 Port btn_raw  input  5  raw asynchronous push-buttons: bit0 up, bit1 down, bit2 left, bit3 right, bit4 center.
REQ-006 Port btn_level  output  5  debounced level per button, same bit order, drives the game controller's up/down/left/right level inputs.
REQ-007 Port btn_press  output  5  single-cycle pulse per button on accepted press.
REQ-008 Port btn_release  output  5  single-cycle pulse per button on accepted release.
REQ-009 Port any_level  output  1  OR of btn_level.

Function
REQ-010 Each btn_raw bit SHALL pass through a 2-flop synchronizer before any other logic; no raw bit is used combinationally.
REQ-011 Each button SHALL have an independent FSM with states IDLE (stable released), PRESS_WAIT, PRESSED (stable pressed) and RELEASE_WAIT, plus its own CNT_W-bit counter.
REQ-012 IDLE: on synchronized bit = 1, go to PRESS_WAIT with counter cleared to 0; otherwise stay.
REQ-013 PRESS_WAIT: synchronized bit = 0 -> back to IDLE, counter 0; bit = 1 and counter = DB_CYCLES-1 -> PRESSED; otherwise counter increments.
REQ-014 PRESSED: on synchronized bit = 0, go to RELEASE_WAIT with counter 0.
REQ-015 RELEASE_WAIT: bit = 1 -> back to PRESSED, counter 0; bit = 0 and counter = DB_CYCLES-1 -> IDLE; otherwise counter increments.
REQ-016 btn_level SHALL be 1 exactly in PRESSED and RELEASE_WAIT, and is registered.
REQ-017 btn_press SHALL be high for exactly the one cycle following the PRESS_WAIT->PRESSED transition. btn_release SHALL be high for exactly the one cycle following the RELEASE_WAIT->IDLE transition.
REQ-018 Latency: with btn_raw held constant, btn_level changes and the matching pulse asserts DB_CYCLES+3 rising edges after the first edge that samples the new raw value.
REQ-019 Any bounce shorter than DB_CYCLES cycles SHALL produce no change on btn_level and no pulse.
REQ-020 Counters SHALL never wrap. A counter stops at DB_CYCLES-1 because the state transition occurs there.
REQ-021 Buttons SHALL be fully independent. Simultaneous presses produce simultaneous pulses, with no priority and no masking.
REQ-022 btn_press and btn_release for the same bit SHALL never be high in the same cycle.

Reset
REQ-023 While rst = 0, synchronizer flops, counters, btn_level, btn_press, btn_release and any_level SHALL be 0, and all FSMs SHALL be in IDLE, regardless of clk.
REQ-024 Reset asserted mid-debounce SHALL abandon the count. After release, a button already held SHALL be re-qualified from IDLE and produce one btn_press.

Structure
REQ-025 Shared package button_pkg SHALL hold the button index constants (BTN_UP=0 .. BTN_CENTER=4), the count NUM_BTN=5, and the 2-bit debounce state encoding.
REQ-026 One sub-module, button_debounce_one, SHALL implement the synchronizer, FSM, counter and pulses for a single bit. The top level instantiates it NUM_BTN times and forms any_level.

Verification (bench uses DB_CYCLES=8, CNT_W=4)
REQ-027 Reset held low 5 cycles, then released with btn_raw=0 -> all outputs 0 for 20 cycles.
REQ-028 btn_raw[3]=1 held -> btn_press[3] high for exactly one cycle at edge 11 after the first sample; btn_level[3]=1 from then on; btn_raw[3]=0 held -> btn_release[3] one cycle 11 edges later, and btn_level[3]=0.
REQ-029 btn_raw[0] toggled with 3-cycle high / 3-cycle low for 60 cycles -> btn_level[0], btn_press[0] and btn_release[0] stay 0 throughout.
REQ-030 btn_raw[1] and btn_raw[2] rise on the same edge -> btn_press[1] and btn_press[2] pulse in the same cycle; other bits stay 0; any_level=1.
REQ-031 btn_raw[4]=1 for 5 cycles, rst pulsed low, btn_raw[4] still high -> outputs 0 during reset, then one btn_press[4] 11 edges after rst returns high.
